// File: rtl/rv32i_mem_arbiter_if.sv
// Bus bundle between the two rv32i requesters (imem fetch, dmem load/store),
// the memory arbiter, and the single-port RAM.
interface rv32i_mem_arbiter_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic        imem_err;

    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        dmem_err;

    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    // Arbiter side
    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata, imem_ack, imem_err,
        input  dmem_req, dmem_we, dmem_wstrb, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack, dmem_err,
        output mem_addr, mem_read, mem_write, mem_wstrb, mem_wdata,
        input  mem_rdata, mem_ready
    );

    // Environment side: requesters and RAM
    modport master (
        output imem_req, imem_addr,
        input  imem_rdata, imem_ack, imem_err,
        output dmem_req, dmem_we, dmem_wstrb, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack, dmem_err,
        input  mem_addr, mem_read, mem_write, mem_wstrb, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/rv32i_mem_arbiter.sv
// Shares one single-port RAM between the imem and dmem ports; one transaction
// at a time, data-first with a fairness cap, and a response timeout.
module rv32i_mem_arbiter #(
    parameter int DATA_BURST_MAX = 4,
    parameter int TIMEOUT        = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    rv32i_mem_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] LP_BURST   = 4'(DATA_BURST_MAX);
    localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT - 1);

    state_t      r_state, w_state;
    logic        r_dmem_own, w_dmem_own;
    logic        r_we, w_we;
    logic [3:0]  r_fair, w_fair;
    logic [7:0]  r_tcnt, w_tcnt;
    logic [31:0] r_mem_addr, w_mem_addr;
    logic        r_mem_read, w_mem_read;
    logic        r_mem_write, w_mem_write;
    logic [3:0]  r_mem_wstrb, w_mem_wstrb;
    logic [31:0] r_mem_wdata, w_mem_wdata;
    logic [31:0] r_imem_rdata, w_imem_rdata;
    logic        r_imem_ack, w_imem_ack;
    logic        r_imem_err, w_imem_err;
    logic [31:0] r_dmem_rdata, w_dmem_rdata;
    logic        r_dmem_ack, w_dmem_ack;
    logic        r_dmem_err, w_dmem_err;
    logic        w_grant_d, w_grant_i;
    logic        w_rsp_err;
    logic [31:0] w_rsp_data;
    logic        w_unused_addr_lsb;

    // Fetches are word-aligned; the low address bits are dropped on purpose.
    assign w_unused_addr_lsb = ^bus.imem_addr[1:0];

    always_comb begin
        w_state      = r_state;
        w_dmem_own   = r_dmem_own;
        w_we         = r_we;
        w_fair       = r_fair;
        w_tcnt       = r_tcnt;
        w_mem_addr   = r_mem_addr;
        w_mem_wdata  = r_mem_wdata;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_wstrb  = 4'b0;
        w_imem_rdata = 32'b0;
        w_imem_ack   = 1'b0;
        w_imem_err   = 1'b0;
        w_dmem_rdata = 32'b0;
        w_dmem_ack   = 1'b0;
        w_dmem_err   = 1'b0;
        w_rsp_err    = 1'b0;
        w_rsp_data   = 32'b0;
        w_grant_d    = bus.dmem_req && (!bus.imem_req || (r_fair < LP_BURST));
        w_grant_i    = bus.imem_req && !w_grant_d;

        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_dmem_own  = 1'b1;
                    w_we        = bus.dmem_we;
                    w_mem_addr  = bus.dmem_addr;
                    w_mem_read  = !bus.dmem_we;
                    w_mem_write = bus.dmem_we;
                    w_mem_wstrb = bus.dmem_we ? bus.dmem_wstrb : 4'b0;
                    w_mem_wdata = bus.dmem_wdata;
                    if (!bus.imem_req)
                        w_fair = 4'b0;
                    else if (r_fair != LP_BURST)
                        w_fair = r_fair + 4'd1;
                    w_state = ISSUE;
                end else if (w_grant_i) begin
                    w_dmem_own  = 1'b0;
                    w_we        = 1'b0;
                    w_mem_addr  = {bus.imem_addr[31:2], 2'b00};
                    w_mem_read  = 1'b1;
                    w_mem_wdata = 32'b0;
                    w_fair      = 4'b0;
                    w_state     = ISSUE;
                end
            end
            ISSUE: begin
                w_tcnt  = 8'b0;
                w_state = WAIT;
            end
            WAIT: begin
                // Response is loaded straight into the ack registers so it is visible in RESP.
                if (bus.mem_ready || (r_tcnt == LP_TO_LAST)) begin
                    w_rsp_err  = !bus.mem_ready;
                    w_rsp_data = (bus.mem_ready && !r_we) ? bus.mem_rdata : 32'b0;
                    if (r_dmem_own) begin
                        w_dmem_ack   = 1'b1;
                        w_dmem_err   = w_rsp_err;
                        w_dmem_rdata = w_rsp_data;
                    end else begin
                        w_imem_ack   = 1'b1;
                        w_imem_err   = w_rsp_err;
                        w_imem_rdata = w_rsp_data;
                    end
                    w_tcnt  = 8'b0;
                    w_state = RESP;
                end else begin
                    w_tcnt = r_tcnt + 8'd1;
                end
            end
            RESP: begin
                w_state = IDLE;
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_dmem_own   <= 1'b0;
            r_we         <= 1'b0;
            r_fair       <= 4'b0;
            r_tcnt       <= 8'b0;
            r_mem_addr   <= 32'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_wstrb  <= 4'b0;
            r_mem_wdata  <= 32'b0;
            r_imem_rdata <= 32'b0;
            r_imem_ack   <= 1'b0;
            r_imem_err   <= 1'b0;
            r_dmem_rdata <= 32'b0;
            r_dmem_ack   <= 1'b0;
            r_dmem_err   <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_dmem_own   <= w_dmem_own;
            r_we         <= w_we;
            r_fair       <= w_fair;
            r_tcnt       <= w_tcnt;
            r_mem_addr   <= w_mem_addr;
            r_mem_read   <= w_mem_read;
            r_mem_write  <= w_mem_write;
            r_mem_wstrb  <= w_mem_wstrb;
            r_mem_wdata  <= w_mem_wdata;
            r_imem_rdata <= w_imem_rdata;
            r_imem_ack   <= w_imem_ack;
            r_imem_err   <= w_imem_err;
            r_dmem_rdata <= w_dmem_rdata;
            r_dmem_ack   <= w_dmem_ack;
            r_dmem_err   <= w_dmem_err;
        end
    end

    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_read   = r_mem_read;
    assign bus.mem_write  = r_mem_write;
    assign bus.mem_wstrb  = r_mem_wstrb;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.imem_rdata = r_imem_rdata;
    assign bus.imem_ack   = r_imem_ack;
    assign bus.imem_err   = r_imem_err;
    assign bus.dmem_rdata = r_dmem_rdata;
    assign bus.dmem_ack   = r_dmem_ack;
    assign bus.dmem_err   = r_dmem_err;
endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Scoreboard bench for rv32i_mem_arbiter: directed transactions against a
// one-cycle-latency RAM model with ready suppression and stray-ready injection.
module tb_rv32i_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rv32i_mem_arbiter_if bus();

    rv32i_mem_arbiter #(.DATA_BURST_MAX(4), .TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } mem_t;

    typedef struct {
        logic        d;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } rsp_t;

    mem_t mem_q[$];
    rsp_t rsp_q[$];

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int last_strobe_cyc = 0;
    logic prev_strobe = 1'b0;

    // RAM model
    logic [31:0] ram [0:1023];
    logic [31:0] ram_rdata = 32'b0;
    logic        ram_ready = 1'b0;
    logic        suppress  = 1'b0;
    logic        inj_ready = 1'b0;

    assign bus.mem_rdata = ram_rdata;
    assign bus.mem_ready = ram_ready | inj_ready;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        ram_ready <= 1'b0;
        if (!suppress && (bus.mem_read || bus.mem_write)) begin
            if (bus.mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_wstrb[b])
                        ram[bus.mem_addr[11:2]][b*8 +: 8] = bus.mem_wdata[b*8 +: 8];
                ram_rdata <= 32'b0;
            end else begin
                ram_rdata <= ram[bus.mem_addr[11:2]];
            end
            ram_ready <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        mem_t m;
        rsp_t r;
        logic strobe;
        strobe = bus.mem_read | bus.mem_write;
        if (strobe) begin
            chk("strobe_one_cycle", prev_strobe, 1'b0);
            last_strobe_cyc = cyc;
            chk("mem_pending", mem_q.size() != 0, 1'b1);
            if (mem_q.size() != 0) begin
                m = mem_q.pop_front();
                chk("mem_addr",  bus.mem_addr,  m.addr);
                chk("mem_read",  bus.mem_read,  m.rd);
                chk("mem_write", bus.mem_write, m.wr);
                chk("mem_wstrb", bus.mem_wstrb, m.strb);
                chk("mem_wdata", bus.mem_wdata, m.wdata);
            end
        end
        prev_strobe = strobe;
        if (bus.imem_ack || bus.dmem_ack) begin
            chk("single_ack", bus.imem_ack & bus.dmem_ack, 1'b0);
            chk("rsp_pending", rsp_q.size() != 0, 1'b1);
            if (rsp_q.size() != 0) begin
                r = rsp_q.pop_front();
                chk("grant_port", bus.dmem_ack, r.d);
                chk("rsp_rdata", r.d ? bus.dmem_rdata : bus.imem_rdata, r.rdata);
                chk("rsp_err",   r.d ? bus.dmem_err   : bus.imem_err,   r.err);
                chk("rsp_latency", 64'(cyc - last_strobe_cyc), 64'(r.lat));
            end
        end
    end

    task automatic push_imem(input logic [31:0] addr, input logic [31:0] rdata,
                             input logic err, input int lat);
        mem_q.push_back('{{addr[31:2], 2'b00}, 1'b1, 1'b0, 4'b0, 32'b0});
        rsp_q.push_back('{1'b0, rdata, err, lat});
    endtask

    task automatic push_dmem(input logic we, input logic [3:0] strb, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input logic err, input int lat);
        mem_q.push_back('{addr, !we, we, we ? strb : 4'b0, wdata});
        rsp_q.push_back('{1'b1, rdata, err, lat});
    endtask

    task automatic wait_ack(input logic d);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = d ? bus.dmem_ack : bus.imem_ack;
        end
        chk("ack_within_bound", seen, 1'b1);
    endtask

    task automatic imem_txn(input logic [31:0] addr, input logic [31:0] rdata,
                            input logic err, input int lat);
        push_imem(addr, rdata, err, lat);
        bus.imem_addr = addr;
        bus.imem_req  = 1'b1;
        wait_ack(1'b0);
        bus.imem_req  = 1'b0;
    endtask

    task automatic dmem_txn(input logic we, input logic [3:0] strb, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input logic err, input int lat);
        push_dmem(we, strb, addr, wdata, rdata, err, lat);
        bus.dmem_we    = we;
        bus.dmem_wstrb = strb;
        bus.dmem_addr  = addr;
        bus.dmem_wdata = wdata;
        bus.dmem_req   = 1'b1;
        wait_ack(1'b1);
        bus.dmem_req   = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_mem_addr"},   bus.mem_addr,   0);
        chk({tag, "_mem_wdata"},  bus.mem_wdata,  0);
        chk({tag, "_imem_rdata"}, bus.imem_rdata, 0);
        chk({tag, "_dmem_rdata"}, bus.dmem_rdata, 0);
        chk({tag, "_ctrl"}, {bus.mem_read, bus.mem_write, bus.mem_wstrb, bus.imem_ack,
                             bus.imem_err, bus.dmem_ack, bus.dmem_err}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        bus.imem_req   = 1'b0;
        bus.imem_addr  = 32'b0;
        bus.dmem_req   = 1'b0;
        bus.dmem_we    = 1'b0;
        bus.dmem_wstrb = 4'b0;
        bus.dmem_addr  = 32'b0;
        bus.dmem_wdata = 32'b0;
        for (int i = 0; i < 1024; i++) ram[i] = 32'b0;
        ram[32'h104 >> 2] = 32'hDEAD_BEEF;
        ram[32'h200 >> 2] = 32'h1122_3344;
        ram[32'h010 >> 2] = 32'h0000_0013;
        ram[32'h040 >> 2] = 32'hCAFE_0001;

        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Fetch from an unaligned address
        imem_txn(32'h0000_0106, 32'hDEAD_BEEF, 1'b0, 2);
        @(negedge clk);

        // Partial store, then load back the merged word
        dmem_txn(1'b1, 4'b0101, 32'h200, 32'hAABB_CCDD, 32'h0, 1'b0, 2);
        @(negedge clk);
        dmem_txn(1'b0, 4'b1111, 32'h200, 32'h0, 32'h11BB_33DD, 1'b0, 2);
        @(negedge clk);

        // Contention: expected order D,D,D,D,I,D,D,D,D,I
        for (int k = 0; k < 10; k++) begin
            if (k == 4 || k == 9) push_imem(32'h010, 32'h0000_0013, 1'b0, 2);
            else push_dmem(1'b0, 4'b0, 32'h040, 32'h0, 32'hCAFE_0001, 1'b0, 2);
        end
        bus.imem_addr  = 32'h010;
        bus.dmem_we    = 1'b0;
        bus.dmem_wstrb = 4'b0;
        bus.dmem_addr  = 32'h040;
        bus.dmem_wdata = 32'h0;
        bus.imem_req   = 1'b1;
        bus.dmem_req   = 1'b1;
        acks = 0;
        for (int i = 0; i < 200 && acks < 10; i++) begin
            @(negedge clk);
            if (bus.imem_ack || bus.dmem_ack) acks++;
        end
        chk("contention_acks", acks, 10);
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        repeat (2) @(negedge clk);

        // Timeout, then a stray ready, then a normal transaction
        suppress = 1'b1;
        dmem_txn(1'b0, 4'b0, 32'h300, 32'h0, 32'h0, 1'b1, 16);
        @(negedge clk);
        inj_ready = 1'b1;
        @(negedge clk);
        inj_ready = 1'b0;
        suppress  = 1'b0;
        repeat (3) @(negedge clk);
        dmem_txn(1'b0, 4'b0, 32'h200, 32'h0, 32'h11BB_33DD, 1'b0, 2);
        @(negedge clk);

        // Reset while waiting for the RAM
        suppress = 1'b1;
        mem_q.push_back('{32'h104, 1'b1, 1'b0, 4'b0, 32'b0});
        bus.imem_addr = 32'h104;
        bus.imem_req  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bus.imem_req = 1'b0;
        @(negedge clk);
        chk_outputs_zero("midop_reset");
        rst = 1'b0;
        inj_ready = 1'b1;
        @(negedge clk);
        inj_ready = 1'b0;
        suppress  = 1'b0;
        repeat (3) @(negedge clk);
        imem_txn(32'h0000_0106, 32'hDEAD_BEEF, 1'b0, 2);

        repeat (4) @(negedge clk);
        chk("rsp_queue_drained", rsp_q.size(), 0);
        chk("mem_queue_drained", mem_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
